fifo_burst_reader: RTL and testbench

- Read-side controller for the team's FIFO. It sits in the FIFO read clock domain, drives `ren_b`, and captures `dout_b`.
- Each transfer is a burst of a requested number of words, presented downstream on a valid/ready stream.
- A 2-entry skid buffer absorbs the FIFO's 1-cycle registered read latency and downstream back-pressure.
- It reports completion with a `done` pulse and counts total words delivered.

---
 rtl/fifo_burst_reader.sv | 139 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - FIFO read-side burst controller with 2-entry skid buffer
module fifo_burst_reader #(
  parameter int FIFO_WIDTH = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_b,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  empty,
  input  logic [FIFO_WIDTH-1:0] dout_b,
  output logic                  ren_b,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  to_issue;
  logic [LEN_WIDTH-1:0]  to_send;
  logic [FIFO_WIDTH-1:0] buf_head;
  logic [FIFO_WIDTH-1:0] buf_tail;
  logic [1:0]            buf_cnt;
  logic                  inflight;
  logic                  handoff;
  logic [1:0]            occ_next;

  // The head of the skid buffer is what downstream sees; last is tied to the send counter.
  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = buf_head;
  assign m_last  = m_valid && (to_send == LEN_WIDTH'(1));
  assign handoff = m_valid && m_ready;

  // Issue a read only if the word it returns is guaranteed a slot, counting this cycle's handoff.
  always_comb begin
    occ_next = buf_cnt + {1'b0, inflight} - {1'b0, handoff};
    ren_b    = (state == RUN) && !empty && (to_issue != '0) && (occ_next < 2'd2);
  end

  // Skid buffer: capture the registered FIFO word, pop on handoff, keep FIFO order.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      buf_head <= '0;
      buf_tail <= '0;
      buf_cnt  <= 2'd0;
      inflight <= 1'b0;
      word_cnt <= '0;
    end else begin
      inflight <= ren_b;
      unique case ({inflight, handoff})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            buf_head <= dout_b;
          end else begin
            buf_tail <= dout_b;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_head <= buf_tail;
          buf_cnt  <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf_head <= dout_b;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= dout_b;
          end
        end
        default: begin
        end
      endcase
      if (handoff) begin
        word_cnt <= word_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Burst sequencing: load counters on start, count issues and handoffs, pulse done once.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      state    <= IDLE;
      to_issue <= '0;
      to_send  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              to_issue <= len;
              to_send  <= len;
              state    <= RUN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ren_b) begin
            to_issue <= to_issue - LEN_WIDTH'(1);
          end
          if (handoff) begin
            to_send <= to_send - LEN_WIDTH'(1);
            if (to_send == LEN_WIDTH'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;
  localparam int W     = 8;
  localparam int LW    = 8;
  localparam int CW    = 16;
  localparam int DEPTH = 1024;

  logic          clk_b = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          empty;
  logic [W-1:0]  dout_b;
  logic          ren_b;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic [CW-1:0] word_cnt;

  always #5 clk_b = ~clk_b;

  fifo_burst_reader #(.FIFO_WIDTH(W), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk_b(clk_b), .rst(rst), .start(start), .len(len), .empty(empty),
    .dout_b(dout_b), .ren_b(ren_b), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // FIFO model with 1-cycle registered read; every popped word is expected downstream in order.
  logic [W-1:0] fifo_mem [DEPTH];
  int wp  = 0;
  int rp  = 0;
  int cyc = 0;
  logic [W-1:0] exp_q [$];
  assign empty = (wp == rp);

  always @(posedge clk_b) begin
    cyc <= cyc + 1;
    if (ren_b && (wp != rp)) begin
      dout_b <= fifo_mem[rp % DEPTH];
      rp     <= rp + 1;
      if (!rst) exp_q.push_back(fifo_mem[rp % DEPTH]);
    end
    if (rst) exp_q.delete();
  end

  task automatic push_word(input logic [W-1:0] w);
    fifo_mem[wp % DEPTH] = w;
    wp++;
  endtask

  // Stream monitor and reference scoreboard, sampled mid-cycle.
  int sent = 0, model_cnt = 0, done_cnt = 0, done_cyc = -1, ren_cnt = 0, cur_len = 0;
  bit stall_prev = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] got_q [$];
  int hcyc_q [$];

  initial forever begin
    @(negedge clk_b);
    if (rst) begin
      model_cnt  = 0;
      sent       = 0;
      stall_prev = 1'b0;
    end else begin
      if (empty) check("ren_while_empty", ren_b, 0);
      if (ren_b) ren_cnt++;
      check("word_cnt_track", word_cnt, model_cnt % 65536);
      if (stall_prev) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid) check("m_last", m_last, (sent + 1 == cur_len) ? 1 : 0);
      else check("m_last_idle", m_last, 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("handoff_unexpected", 1, 0);
        else check("data_order", m_data, exp_q.pop_front());
        got_q.push_back(m_data);
        hcyc_q.push_back(cyc);
        sent++;
        model_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        sent = 0;
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  task automatic do_start(input int l);
    cur_len = l;
    start   = 1'b1;
    len     = LW'(l);
    tick();
    start   = 1'b0;
  endtask

  // mode 0: always ready; 1: toggle; 2: random; 3: toggle, then 5-cycle stall, then ready.
  task automatic run_burst(input int mode, input int d0, input int limit);
    int i = 0;
    while (done_cnt == d0 && i < limit) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = i[0];
        2: m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = (i < 8) ? i[0] : ((i < 13) ? 1'b0 : 1'b1);
      endcase
      #1;
      if (mode == 3 && i >= 10 && i <= 12) check("stall_no_ren", ren_b, 0);
      tick();
      i++;
    end
    check("burst_done_seen", (done_cnt > d0) ? 1 : 0, 1);
    m_ready = 1'b1;
  endtask

  typedef struct {
    int len;
    int mode;
    int exp_words;
    int exp_reads;
    int exp_done;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, base, r0, rp0, d0, tot, pend, rl, rp_snap;
    vecs[0] = '{8,   3, 8,   8,   1};
    vecs[1] = '{1,   0, 1,   1,   1};
    vecs[2] = '{5,   1, 5,   5,   1};
    vecs[3] = '{12,  2, 12,  12,  1};
    vecs[4] = '{200, 2, 200, 200, 1};
    vecs[5] = '{3,   1, 3,   3,   1};

    // Reset with start held high: nothing moves, FIFO untouched.
    rst = 1'b1; start = 1'b1; len = 8'd5; m_ready = 1'b1;
    for (int k = 1; k <= 16; k++) push_word(W'(k));
    tick();
    tick();
    check("rst_ren", ren_b, 0);
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_no_reads", rp, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    tot = 0;

    // Full-rate burst of 16: latency and 1 word/cycle.
    s = cyc; base = got_q.size(); r0 = ren_cnt; rp0 = rp; d0 = done_cnt;
    do_start(16);
    check("first_ren_cycle1", ren_b, 1);
    run_burst(0, d0, 100);
    tot += 16;
    check("full_count", got_q.size() - base, 16);
    for (int k = 0; k < 16; k++) begin
      if (got_q.size() > base + k) begin
        check("full_data", got_q[base + k], k + 1);
        check("full_cycle", hcyc_q[base + k], s + 3 + k);
      end
    end
    check("full_done_cycle", done_cyc, s + 19);
    check("full_ren_pulses", ren_cnt - r0, 16);
    check("full_reads", rp - rp0, 16);
    check("full_word_cnt", word_cnt, tot);

    // Table of bursts under different back-pressure patterns.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].len; k++) push_word(W'($urandom));
      base = got_q.size(); rp0 = rp; d0 = done_cnt;
      do_start(vecs[v].len);
      run_burst(vecs[v].mode, d0, 2000);
      tot += vecs[v].len;
      check("vec_words", got_q.size() - base, vecs[v].exp_words);
      check("vec_reads", rp - rp0, vecs[v].exp_reads);
      check("vec_done", done_cnt - d0, vecs[v].exp_done);
      check("vec_word_cnt", word_cnt, tot);
      check("vec_idle", busy, 0);
    end

    // Empty stall: 2 words available, 3 more arrive later.
    push_word(8'hA1); push_word(8'hA2);
    base = got_q.size(); rp0 = rp; d0 = done_cnt;
    do_start(5);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("stall_busy", busy, 1);
    end
    check("stall_partial", got_q.size() - base, 2);
    push_word(8'hA3); push_word(8'hA4); push_word(8'hA5);
    run_burst(0, d0, 100);
    tot += 5;
    check("stall_words", got_q.size() - base, 5);
    check("stall_done", done_cnt - d0, 1);
    check("stall_reads", rp - rp0, 5);
    if (got_q.size() >= base + 5) check("stall_last_word", got_q[base + 4], 8'hA5);

    // len=0: immediate done, no reads.
    for (int k = 0; k < 6; k++) push_word(W'(8'h30 + k));
    rp0 = rp; d0 = done_cnt;
    do_start(0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 1);
    tick();
    check("len0_done_clear", done, 0);
    check("len0_idle", busy, 0);
    check("len0_reads", rp - rp0, 0);
    check("len0_word_cnt", word_cnt, tot);
    check("len0_one_done", done_cnt - d0, 1);

    // start during RUN is ignored.
    base = got_q.size(); rp0 = rp; d0 = done_cnt;
    do_start(6);
    tick(); tick();
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    run_burst(0, d0, 100);
    tot += 6;
    for (int k = 0; k < 5; k++) tick();
    check("ignore_reads", rp - rp0, 6);
    check("ignore_words", got_q.size() - base, 6);
    check("ignore_done", done_cnt - d0, 1);
    check("ignore_idle", busy, 0);

    // Reset after 4 handoffs of a 10-word burst, then a fresh 3-word burst.
    for (int k = 0; k < 20; k++) push_word(W'(8'h50 + k));
    base = got_q.size(); d0 = done_cnt;
    do_start(10);
    m_ready = 1'b1;
    for (int k = 0; k < 100 && got_q.size() < base + 4; k++) tick();
    check("mid_handoffs", got_q.size() - base, 4);
    m_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ren", ren_b, 0);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_word_cnt", word_cnt, 0);
    tick();
    check("mid_no_done", done_cnt - d0, 0);
    tot = 0;
    rp_snap = rp; base = got_q.size(); d0 = done_cnt;
    do_start(3);
    run_burst(0, d0, 100);
    tot += 3;
    check("post_rst_words", got_q.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      if (got_q.size() > base + k) check("post_rst_data", got_q[base + k], fifo_mem[(rp_snap + k) % DEPTH]);
    end
    check("post_rst_word_cnt", word_cnt, tot);

    // Randomised bursts with a trickling FIFO and random back-pressure.
    for (int b = 0; b < 8; b++) begin
      rl = $urandom_range(1, 40);
      pend = rl;
      base = got_q.size(); rp0 = rp; d0 = done_cnt;
      do_start(rl);
      for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
        m_ready = ($urandom_range(0, 3) != 0);
        if (pend > 0 && $urandom_range(0, 1) == 1) begin
          push_word(W'($urandom));
          pend--;
        end
        tick();
      end
      check("rand_done_seen", (done_cnt > d0) ? 1 : 0, 1);
      m_ready = 1'b1;
      tot += rl;
      check("rand_words", got_q.size() - base, rl);
      check("rand_reads", rp - rp0, rl);
      check("rand_word_cnt", word_cnt, tot);
    end

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
